// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : Time-multiplexed scan driver for a 4-digit seven-segment
//             display. Rotates through four BCD nibbles on a programmable
//             refresh tick. It presents one nibble plus a one-hot anode
//             select per digit. New values are double-buffered and take
//             effect only at frame boundaries, so a frame never mixes old
//             and new digits.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous active-high reset
//             disp_en    - global enable; low blanks outputs, scan continues
//             load       - one-cycle strobe capturing value into pending buf
//             value      - packed BCD, [3:0] = digit 0 (rightmost)
//             blank_lz   - suppress leading zeros on digits 3..1
//             digit_en   - decoder enable for the current digit
//             digit_num  - nibble of the current digit
//             anode_sel  - active-high one-hot digit select
//             frame_done - one-cycle pulse in the first cycle of digit 0
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        digit_en,
  output logic [3:0]  digit_num,
  output logic [3:0]  anode_sel,
  output logic        frame_done
);

  localparam int C_DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_MAX = C_DIV_W'(REFRESH_DIV - 1);

  logic [C_DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [1:0]         digit_idx_q,  digit_idx_d;
  logic [15:0]        disp_q,       disp_d;
  logic [15:0]        pend_q,       pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic               frame_done_q;

  logic               tick;
  logic               wrap;
  logic [3:0]         nib_zero;
  logic [3:0]         lz_blank;

  assign tick = (div_cnt_q == C_DIV_MAX);
  assign wrap = tick && (digit_idx_q == 2'd3);

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + C_DIV_W'(1);
    digit_idx_d  = tick ? digit_idx_q + 2'd1 : digit_idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (load) begin
      pend_d       = value;
      pend_valid_d = 1'b1;
    end

    // A load landing on the wrap cycle bypasses the pending buffer so it
    // still makes the very next frame; the pending flag is consumed either way.
    if (wrap) begin
      if (load) begin
        disp_d = value;
      end else if (pend_valid_q) begin
        disp_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      frame_done_q <= wrap;
    end
  end

  // Digit i (i >= 1) is a leading zero when it and every digit to its left
  // are zero. Digit 0 always shows so a zero value still displays "0".
  assign nib_zero[0] = (disp_q[3:0]   == 4'h0);
  assign nib_zero[1] = (disp_q[7:4]   == 4'h0);
  assign nib_zero[2] = (disp_q[11:8]  == 4'h0);
  assign nib_zero[3] = (disp_q[15:12] == 4'h0);

  assign lz_blank[0] = 1'b0;
  assign lz_blank[1] = blank_lz && nib_zero[3] && nib_zero[2] && nib_zero[1];
  assign lz_blank[2] = blank_lz && nib_zero[3] && nib_zero[2];
  assign lz_blank[3] = blank_lz && nib_zero[3];

  always_comb begin
    case (digit_idx_q)
      2'd0:    digit_num = disp_q[3:0];
      2'd1:    digit_num = disp_q[7:4];
      2'd2:    digit_num = disp_q[11:8];
      default: digit_num = disp_q[15:12];
    endcase
  end

  assign digit_en   = disp_en && !lz_blank[digit_idx_q];
  assign anode_sel  = disp_en ? (4'b0001 << digit_idx_q) : 4'b0000;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
